// File: rtl/d_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with a one-entry
// posted write buffer and 4-word line fills from SDRAM.
module d_cache_controller #(
   parameter int ADDR_WIDTH = 16,
   parameter int INDEX_BITS = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_ren,
   input  logic                  data_wren,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  d_cache_read_miss,
   output logic                  d_cache_write_miss,
   output logic                  mem_req,
   output logic                  mem_wren,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = LINES * 4;

   typedef enum logic [2:0] {IDLE, FLUSH, FILL_REQ, FILL, DONE} state_t;
   state_t state, state_nxt;

   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_array [LINES];
   logic [DATA_WIDTH-1:0] data_ram  [WORDS];

   logic                  wb_valid;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic [1:0]            cnt;

   logic [INDEX_BITS-1:0] idx, fill_idx;
   logic [TAG_W-1:0]      tag;
   logic                  hit, is_idle, rd_req, wb_ack, wr_acc, rd_acc;
   logic                  ram_we;
   logic [INDEX_BITS+1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;

   assign idx      = data_address[INDEX_BITS+1:2];
   assign tag      = data_address[ADDR_WIDTH-1:INDEX_BITS+2];
   assign fill_idx = fill_addr[INDEX_BITS+1:2];
   assign hit      = valid[idx] && (tag_array[idx] == tag);
   assign is_idle  = (state == IDLE);
   // a write request beats a simultaneous read; the read is simply dropped
   assign rd_req   = data_ren && !data_wren;
   assign wb_ack   = wb_valid && mem_ack;
   assign wr_acc   = !rst && data_wren && is_idle && (!wb_valid || wb_ack);
   assign rd_acc   = !rst && rd_req && is_idle && hit;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (rd_req && !hit) state_nxt = wb_valid ? FLUSH : FILL_REQ;
         FLUSH:    if (!wb_valid) state_nxt = FILL_REQ;
         FILL_REQ: if (mem_ack) state_nxt = FILL;
         FILL:     if (mem_rvalid && cnt == 2'd3) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // the buffer is only ever occupied in IDLE/FLUSH, so it owns the bus then
   always_comb begin
      d_cache_read_miss  = !rst && rd_req && !(hit && is_idle);
      d_cache_write_miss = !rst && data_wren && !(is_idle && (!wb_valid || wb_ack));
      mem_req     = wb_valid || (state == FILL_REQ);
      mem_wren    = wb_valid;
      mem_wdata   = wb_valid ? wb_data : '0;
      mem_address = '0;
      if (wb_valid)               mem_address = wb_addr;
      else if (state == FILL_REQ) mem_address = fill_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid      <= '0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         fill_addr  <= '0;
         cnt        <= 2'd0;
         data_rdata <= '0;
      end else begin
         if (wr_acc) begin
            wb_valid <= 1'b1;
            wb_addr  <= data_address;
            wb_data  <= data_wdata;
         end else if (wb_ack) begin
            wb_valid <= 1'b0;
         end
         if (is_idle && rd_req && !hit)
            fill_addr <= {data_address[ADDR_WIDTH-1:2], 2'b00};
         if (state == FILL_REQ && mem_ack) begin
            valid[fill_idx] <= 1'b0;
            cnt             <= 2'd0;
         end
         if (state == FILL && mem_rvalid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) valid[fill_idx] <= 1'b1;
         end
         if (rd_acc) data_rdata <= data_ram[data_address[INDEX_BITS+1:0]];
      end
   end

   // single RAM write port: fill beats and write hits never coincide
   always_comb begin
      ram_we    = !rst && ((wr_acc && hit) || (state == FILL && mem_rvalid));
      ram_waddr = data_address[INDEX_BITS+1:0];
      ram_wdata = data_wdata;
      if (state == FILL) begin
         ram_waddr = {fill_idx, cnt};
         ram_wdata = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == FILL_REQ && mem_ack)
         tag_array[fill_idx] <= fill_addr[ADDR_WIDTH-1:INDEX_BITS+2];
      if (ram_we) data_ram[ram_waddr] <= ram_wdata;
   end
endmodule

// File: tb/tb_d_cache_controller.sv
// Bench for d_cache_controller: SDRAM responder, architectural memory model,
// and directed read/write scenarios with literal stall and data expectations.
module tb_d_cache_controller;
   logic        clk, rst;
   logic        data_ren, data_wren;
   logic [15:0] data_address, data_wdata, data_rdata;
   logic        d_cache_read_miss, d_cache_write_miss;
   logic        mem_req, mem_wren, mem_ack, mem_rvalid;
   logic [15:0] mem_address, mem_wdata, mem_rdata;

   d_cache_controller dut (
      .clk(clk), .rst(rst), .data_ren(data_ren), .data_wren(data_wren),
      .data_address(data_address), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .d_cache_read_miss(d_cache_read_miss), .d_cache_write_miss(d_cache_write_miss),
      .mem_req(mem_req), .mem_wren(mem_wren), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   initial begin clk = 0; forever #5 clk = ~clk; end

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // architectural memory (CPU view) and SDRAM contents
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] sdram   [logic [15:0]];
   function automatic logic [15:0] init_val(input logic [15:0] a);
      return a ^ 16'hC3C3;
   endfunction
   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction
   function automatic logic [15:0] sd_rd(input logic [15:0] a);
      return sdram.exists(a) ? sdram[a] : init_val(a);
   endfunction

   // which lines the cache must hold, derived from the fills the bench serves
   logic       mvalid [64];
   logic [7:0] mtag   [64];
   function automatic logic model_hit(input logic [15:0] a);
      return mvalid[a[7:2]] && (mtag[a[7:2]] == a[15:8]);
   endfunction

   logic [31:0] wq [$];
   logic [16:0] log_q [$];

   // SDRAM responder
   int ack_delay = 1, rphase = 0, rcnt = 0, rbeat = 0, beats_sent = 0;
   logic        rwr;
   logic [15:0] raddr, rwd;
   initial begin
      mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
      for (int i = 0; i < 64; i++) begin mvalid[i] = 0; mtag[i] = 0; end
      forever begin
         @(posedge clk); #1;
         mem_ack = 0; mem_rvalid = 0;
         if (rst) begin
            rphase = 0;
            for (int i = 0; i < 64; i++) mvalid[i] = 0;
            continue;
         end
         case (rphase)
            0: if (mem_req) begin
                  rwr = mem_wren; raddr = mem_address; rwd = mem_wdata;
                  rcnt = ack_delay; rphase = 1;
               end
            1: if (rcnt > 0) rcnt--;
               else begin
                  mem_ack = 1;
                  log_q.push_back({rwr, raddr});
                  if (rwr) begin
                     sdram[raddr] = rwd;
                     if (wq.size() == 0) chk("unexpected_sdram_write", {raddr, rwd}, 32'h0);
                     else chk("sdram_write_order", {raddr, rwd}, wq.pop_front());
                     rphase = 0;
                  end else begin
                     mvalid[raddr[7:2]] = 0;
                     mtag[raddr[7:2]] = raddr[15:8];
                     rbeat = 0; beats_sent = 0; rphase = 2;
                  end
               end
            2: begin
                  mem_rvalid = 1;
                  mem_rdata = sd_rd(raddr + 16'(rbeat));
                  rbeat++; beats_sent = rbeat;
                  if (rbeat == 4) begin mvalid[raddr[7:2]] = 1; rphase = 0; end
               end
            default: rphase = 0;
         endcase
      end
   end

   // per-cycle compare against the model
   logic        rd_pend = 0, prev_req = 0, prev_ack = 0;
   logic [15:0] rd_exp;
   logic [32:0] prev_fields;
   always @(negedge clk) begin
      if (rst) begin
         rd_pend = 0; prev_req = 0;
      end else begin
         if (rd_pend) chk("rdata_model", data_rdata, rd_exp);
         rd_pend = 0;
         if (data_ren && !data_wren) begin
            if (!model_hit(data_address)) chk("miss_model", d_cache_read_miss, 1);
            if (!d_cache_read_miss) begin rd_pend = 1; rd_exp = ref_rd(data_address); end
         end
         if (data_wren && !d_cache_write_miss) begin
            ref_mem[data_address] = data_wdata;
            wq.push_back({data_address, data_wdata});
         end
         if (prev_req && !prev_ack)
            chk("mem_req_stable", {31'b0, mem_req, mem_wren, mem_address, mem_wdata} , {31'b0, 1'b1, prev_fields});
         prev_req = mem_req; prev_ack = mem_ack;
         prev_fields = {mem_wren, mem_address, mem_wdata};
      end
   end

   task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input int exp_stall, input string nm);
      int st = 0;
      data_ren = 1; data_address = a;
      @(negedge clk);
      while (d_cache_read_miss && st < 200) begin st++; @(negedge clk); end
      chk({nm, "_stall"}, st, exp_stall);
      @(posedge clk); #1 data_ren = 0;
      @(negedge clk);
      chk({nm, "_data"}, data_rdata, exp);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int exp_stall, input string nm);
      int st = 0;
      data_wren = 1; data_address = a; data_wdata = d;
      @(negedge clk);
      while (d_cache_write_miss && st < 200) begin st++; @(negedge clk); end
      chk({nm, "_stall"}, st, exp_stall);
      @(posedge clk); #1 data_wren = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (mem_req && n < 100) begin n++; @(negedge clk); end
      chk("drain_timeout", n < 100, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1; data_ren = 0; data_wren = 0; data_address = 0; data_wdata = 0;
      for (int i = 0; i < 4; i++) begin
         sdram[16'h0040 + 16'(i)]   = 16'hA000 + 16'(i);
         ref_mem[16'h0040 + 16'(i)] = 16'hA000 + 16'(i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {data_rdata, mem_address}, 32'h0);
      chk("rst_flags", {d_cache_read_miss, d_cache_write_miss, mem_req, mem_wren}, 4'h0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("post_rst_flags", {mem_req, mem_wren, d_cache_read_miss, d_cache_write_miss}, 4'h0);
      chk("post_rst_data", {mem_wdata, data_rdata}, 32'h0);
      @(posedge clk); #1;

      // cold miss fill, then a hit in the same line
      do_read(16'h0040, 16'hA000, 9, "fill_0040");
      do_read(16'h0042, 16'hA002, 0, "hit_0042");

      // write hit posts through the buffer and updates the line
      do_write(16'h0041, 16'h1234, 0, "wr_0041");
      @(negedge clk);
      chk("wr_0041_bus", {mem_req, mem_wren, mem_address}, {2'b11, 16'h0041});
      chk("wr_0041_wdata", mem_wdata, 16'h1234);
      @(posedge clk); #1;
      do_read(16'h0041, 16'h1234, 0, "raw_hit_0041");
      wait_idle();

      // second write stalls until the first is acked
      do_write(16'h0100, 16'h1111, 0, "wr_0100");
      do_write(16'h0200, 16'h2222, 2, "wr_0200");
      @(negedge clk);
      chk("wr_0200_bus", {mem_wren, mem_address}, {1'b1, 16'h0200});
      @(posedge clk); #1;
      wait_idle();
      do_read(16'h0100, 16'h1111, 9, "noalloc_0100");

      // buffered miss write then read: flush precedes the fill
      log_q.delete();
      do_write(16'h0500, 16'hBEEF, 0, "wr_0500");
      do_read(16'h0500, 16'hBEEF, 12, "flush_0500");
      chk("flush_order_n", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         chk("flush_order0", log_q[0], {1'b1, 16'h0500});
         chk("flush_order1", log_q[1], {1'b0, 16'h0500});
      end

      // conflict eviction
      do_read(16'h1040, init_val(16'h1040), 9, "conflict_1040");
      do_read(16'h0040, 16'hA000, 9, "refill_0040");
      do_read(16'h0041, 16'h1234, 0, "refill_0041");

      // reset in the middle of a fill
      data_ren = 1; data_address = 16'h2080;
      n = 0;
      @(negedge clk);
      while (!(rphase == 2 && beats_sent == 2) && n < 200) begin n++; @(negedge clk); end
      chk("midfill_reach", n < 200, 1);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      chk("midfill_rst_flags", {mem_req, d_cache_read_miss, d_cache_write_miss}, 3'b000);
      @(posedge clk); #1 data_ren = 0;
      @(negedge clk);
      chk("midfill_rst_req", mem_req, 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("midfill_post_req", mem_req, 0);
      @(posedge clk); #1;
      do_read(16'h2080, init_val(16'h2080), 9, "refetch_2080");
      do_read(16'h2083, init_val(16'h2083), 0, "refetch_2083");

      wait_idle();
      chk("wq_empty", wq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
